hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage CPU.
- Decides each cycle whether the PC and the pipeline registers advance, hold or flush, for three causes: load-use hazards, taken branches resolved in ID, and data-cache miss stalls.
- Drives the stall/flush/MemStall inputs of every pipeline register and the PC write enable.
- Keeps saturating performance counters and a miss-stall watchdog.

Parameters:
- CNT_W, 16, width of each performance counter.
- TIMEOUT, 255, consecutive cache-stall cycles after which err_o sets.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  leave IDLE and begin execution; sampled only in IDLE
- idex_memread_i  in  1  instruction in EX is a load
- idex_rd_i  in  5  destination register of instruction in EX
- ifid_rs1_i  in  5  rs1 of instruction in ID
- ifid_rs2_i  in  5  rs2 of instruction in ID
- branch_taken_i  in  1  branch in ID resolved taken (combinational)
- dmem_stall_i  in  1  data cache busy with a miss
- pc_write_o  out  1  PC update enable
- ifid_stall_o  out  1  hold IF/ID
- ifid_flush_o  out  1  zero IF/ID
- idex_flush_o  out  1  zero ID/EX (bubble)
- mem_stall_o  out  1  freeze all pipeline registers and PC
- state_o  out  2  current FSM state encoding
- cnt_loaduse_o  out  CNT_W  load-use stall events
- cnt_flush_o  out  CNT_W  branch flush events
- cnt_memstall_o  out  CNT_W  cycles frozen by cache
- err_o  out  1  sticky watchdog error

Behaviour:
- Reset is synchronous, active-high. On the edge with rst_i=1: state=IDLE, all counters=0, wait counter=0, err_o=0. This applies mid-operation too, including in MEMWAIT.
- Outputs are a combinational function of state and inputs. Counters, state and err_o are registered.
- States: IDLE=0, RUN=1, MEMWAIT=2; encoding 3 is unused and goes to IDLE.
- IDLE outputs: pc_write_o=0, ifid_flush_o=1, idex_flush_o=1, ifid_stall_o=0, mem_stall_o=0. The pipeline therefore comes up empty.
- IDLE transition: goes to RUN on the edge where start_i=1. start_i is ignored in other states.
- Load-use detection: lu = idex_memread_i && idex_rd_i!=0 && (idex_rd_i==ifid_rs1_i || idex_rd_i==ifid_rs2_i).
- Output priority in RUN/MEMWAIT:
  1. If dmem_stall_i=1: mem_stall_o=1, pc_write_o=0, all flushes=0, ifid_stall_o=0. The freeze wins over everything.
  2. Else if lu: pc_write_o=0, ifid_stall_o=1, idex_flush_o=1, ifid_flush_o=0. branch_taken_i is ignored; the branch re-evaluates next cycle.
  3. Else if branch_taken_i: ifid_flush_o=1, pc_write_o=1.
  4. Else: pc_write_o=1, all others 0.
- RUN→MEMWAIT on the edge where dmem_stall_i=1.
- MEMWAIT→RUN on the edge where dmem_stall_i=0. That cycle is already evaluated with the RUN rules, so there are no extra bubbles (zero added latency).
- Counters saturate at all-ones and never wrap. They increment only in RUN/MEMWAIT:
  - cnt_loaduse_o: +1 per cycle where rule 2 applies.
  - cnt_flush_o: +1 per cycle where rule 3 applies.
  - cnt_memstall_o: +1 per cycle with dmem_stall_i=1.
- Watchdog:
  - Wait counter increments each cycle dmem_stall_i=1 in RUN/MEMWAIT; clears when dmem_stall_i=0.
  - When it reaches TIMEOUT, err_o=1 and stays set until reset.
  - The wait counter saturates. The FSM is not otherwise affected.
- Simultaneous dmem_stall_i, lu and branch_taken_i: freeze only, no counters except cnt_memstall_o.

Decomposition:
- Shared package hazard_ctrl_pkg holds:
  - state enum (IDLE/RUN/MEMWAIT, 2-bit)
  - REG_ZERO=5'd0
- One natural sub-module: sat_counter (parameter W; inputs clk_i, rst_i, inc_i; output cnt_o). Instantiated for the three perf counters and the watchdog.

Test Plan:
- Reset then start_i=1 for one cycle → IDLE outputs (flushes=1, pc_write_o=0) before the edge; RUN after, with pc_write_o=1 and all flushes 0.
- RUN, idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5 for one cycle → pc_write_o=0, ifid_stall_o=1, idex_flush_o=1; cnt_loaduse_o=1. Repeat with idex_rd_i=0 → no stall.
- lu and branch_taken_i asserted together → only the stall applies, ifid_flush_o=0. Next cycle branch alone → ifid_flush_o=1, cnt_flush_o=1.
- dmem_stall_i=1 for 10 cycles with branch_taken_i=1 → mem_stall_o=1 throughout, state_o=2 from the 2nd cycle, cnt_memstall_o=10, cnt_flush_o unchanged. First cycle after release: ifid_flush_o=1.
- TIMEOUT=4, dmem_stall_i held 6 cycles → err_o rises after the 4th stall cycle and stays 1 after release. rst_i clears it along with all counters and returns to IDLE.
- With CNT_W=2, five consecutive branch flushes → cnt_flush_o saturates at 3.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   state_e   : controller FSM encoding (IDLE=0, RUN=1, MEMWAIT=2; 3 unused)
//   REG_ZERO  : architectural zero register index, never a real hazard source
//   load_use(): load-use hazard between the load in EX and the instruction in ID
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic load_use(input logic       memread,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    return memread && (rd != REG_ZERO) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk_i : clock
//   rst_i : synchronous active-high clear
//   inc_i : increment request, ignored once the counter is all-ones
//   cnt_o : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline controller for the 5-stage CPU.
// Each cycle decides whether PC and pipeline registers advance, hold or flush
// for load-use hazards, taken branches resolved in ID and data-cache misses.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   start_i                : leave IDLE (sampled only in IDLE)
//   idex_memread_i/rd_i    : load in EX and its destination
//   ifid_rs1_i/rs2_i       : sources of the instruction in ID
//   branch_taken_i         : branch in ID resolved taken
//   dmem_stall_i           : data cache busy with a miss
//   pc_write_o, ifid_stall_o, ifid_flush_o, idex_flush_o, mem_stall_o
//                          : pipeline register / PC controls (combinational)
//   state_o                : FSM state encoding
//   cnt_loaduse_o, cnt_flush_o, cnt_memstall_o : saturating perf counters
//   err_o                  : sticky miss-stall watchdog error
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             branch_taken_i,
  input  logic             dmem_stall_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             mem_stall_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cnt_loaduse_o,
  output logic [CNT_W-1:0] cnt_flush_o,
  output logic [CNT_W-1:0] cnt_memstall_o,
  output logic             err_o
);

  // Wait counter only needs to reach TIMEOUT; it saturates above that.
  localparam int unsigned     WD_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            lu;
  logic            active;
  logic            inc_lu, inc_fl, inc_ms;
  logic            wd_clr;
  logic [WD_W-1:0] wait_cnt;
  logic            err_q;

  assign lu = load_use(idex_memread_i, idex_rd_i, ifid_rs1_i, ifid_rs2_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RUN and MEMWAIT share one rule set; MEMWAIT only records that the
  // previous cycle was frozen, so leaving it costs no extra bubble.
  always_comb begin
    state_d      = state_q;
    pc_write_o   = 1'b0;
    ifid_stall_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    mem_stall_o  = 1'b0;
    active       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN, ST_MEMWAIT: begin
        active  = 1'b1;
        state_d = dmem_stall_i ? ST_MEMWAIT : ST_RUN;
        if (dmem_stall_i) begin
          mem_stall_o = 1'b1;
        end else if (lu) begin
          ifid_stall_o = 1'b1;
          idex_flush_o = 1'b1;
        end else if (branch_taken_i) begin
          ifid_flush_o = 1'b1;
          pc_write_o   = 1'b1;
        end else begin
          pc_write_o = 1'b1;
        end
      end
      default: begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        state_d      = ST_IDLE;
      end
    endcase
  end

  assign inc_lu = active && !dmem_stall_i && lu;
  assign inc_fl = active && !dmem_stall_i && !lu && branch_taken_i;
  assign inc_ms = active && dmem_stall_i;

  sat_counter #(.W(CNT_W)) u_cnt_loaduse (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (inc_lu), .cnt_o (cnt_loaduse_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (inc_fl), .cnt_o (cnt_flush_o)
  );

  sat_counter #(.W(CNT_W)) u_cnt_memstall (
    .clk_i (clk_i), .rst_i (rst_i), .inc_i (inc_ms), .cnt_o (cnt_memstall_o)
  );

  // Any cycle without a miss breaks the run of consecutive stall cycles.
  assign wd_clr = rst_i || !dmem_stall_i;

  sat_counter #(.W(WD_W)) u_wait_cnt (
    .clk_i (clk_i), .rst_i (wd_clr), .inc_i (inc_ms), .cnt_o (wait_cnt)
  );

  // Set on the edge where the wait count steps onto TIMEOUT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (inc_ms && (wait_cnt >= WD_LAST)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic             idex_memread_i = 1'b0;
  logic [4:0]       idex_rd_i = '0;
  logic [4:0]       ifid_rs1_i = '0;
  logic [4:0]       ifid_rs2_i = '0;
  logic             branch_taken_i = 1'b0;
  logic             dmem_stall_i = 1'b0;
  logic             pc_write_o, ifid_stall_o, ifid_flush_o, idex_flush_o, mem_stall_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cnt_loaduse_o, cnt_flush_o, cnt_memstall_o;
  logic             err_o;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .ifid_rs1_i     (ifid_rs1_i),
    .ifid_rs2_i     (ifid_rs2_i),
    .branch_taken_i (branch_taken_i),
    .dmem_stall_i   (dmem_stall_i),
    .pc_write_o     (pc_write_o),
    .ifid_stall_o   (ifid_stall_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_flush_o   (idex_flush_o),
    .mem_stall_o    (mem_stall_o),
    .state_o        (state_o),
    .cnt_loaduse_o  (cnt_loaduse_o),
    .cnt_flush_o    (cnt_flush_o),
    .cnt_memstall_o (cnt_memstall_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // m_running: controller has been started; m_froze: previous running cycle
  // was a cache freeze (reported as state 2).
  bit m_valid = 0;
  bit m_running, m_froze, m_err;
  int m_lu, m_fl, m_ms, m_wait;

  always @(negedge clk) begin
    bit hit, e_pc, e_st, e_iff, e_idf, e_ms;
    int e_state;
    hit = idex_memread_i && idex_rd_i != 0 &&
          (idex_rd_i == ifid_rs1_i || idex_rd_i == ifid_rs2_i);
    if (m_valid) begin
      e_pc = 0; e_st = 0; e_iff = 0; e_idf = 0; e_ms = 0;
      if (!m_running) begin e_iff = 1; e_idf = 1; end
      else if (dmem_stall_i) e_ms = 1;
      else if (hit) begin e_st = 1; e_idf = 1; end
      else if (branch_taken_i) begin e_iff = 1; e_pc = 1; end
      else e_pc = 1;
      e_state = !m_running ? 0 : (m_froze ? 2 : 1);
      chk("pc_write", int'(pc_write_o), int'(e_pc));
      chk("ifid_stall", int'(ifid_stall_o), int'(e_st));
      chk("ifid_flush", int'(ifid_flush_o), int'(e_iff));
      chk("idex_flush", int'(idex_flush_o), int'(e_idf));
      chk("mem_stall", int'(mem_stall_o), int'(e_ms));
      chk("state", int'(state_o), e_state);
      chk("cnt_loaduse", int'(cnt_loaduse_o), m_lu);
      chk("cnt_flush", int'(cnt_flush_o), m_fl);
      chk("cnt_memstall", int'(cnt_memstall_o), m_ms);
      chk("err", int'(err_o), int'(m_err));
    end
    // advance model to the state after the coming rising edge
    if (rst_i) begin
      m_valid = 1; m_running = 0; m_froze = 0; m_err = 0;
      m_lu = 0; m_fl = 0; m_ms = 0; m_wait = 0;
    end else if (m_valid) begin
      if (!dmem_stall_i) m_wait = 0;
      if (!m_running) begin
        if (start_i) begin m_running = 1; m_froze = 0; end
      end else begin
        m_froze = dmem_stall_i;
        if (dmem_stall_i) begin
          if (m_ms < CMAX) m_ms++;
          m_wait++;
          if (m_wait >= TIMEOUT) m_err = 1;
        end else if (hit) begin
          if (m_lu < CMAX) m_lu++;
        end else if (branch_taken_i) begin
          if (m_fl < CMAX) m_fl++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    start_i = 0; idex_memread_i = 0; idex_rd_i = 0; ifid_rs1_i = 0;
    ifid_rs2_i = 0; branch_taken_i = 0; dmem_stall_i = 0;
  endtask

  initial begin
    int run;
    clr_in();
    rst_i = 1;
    repeat (2) step();
    rst_i = 0;

    // reset state / IDLE outputs with start pending
    start_i = 1; #1;
    chk("lit_idle_pc", int'(pc_write_o), 0);
    chk("lit_idle_iff", int'(ifid_flush_o), 1);
    chk("lit_idle_idf", int'(idex_flush_o), 1);
    chk("lit_idle_state", int'(state_o), 0);
    chk("lit_rst_cnt", int'(cnt_flush_o) + int'(cnt_loaduse_o) + int'(cnt_memstall_o), 0);
    step(); start_i = 0; #1;
    chk("lit_run_state", int'(state_o), 1);
    chk("lit_run_pc", int'(pc_write_o), 1);
    chk("lit_run_flush", int'(ifid_flush_o) + int'(idex_flush_o), 0);

    // load-use on rs2
    idex_memread_i = 1; idex_rd_i = 5; ifid_rs2_i = 5; #1;
    chk("lit_lu_pc", int'(pc_write_o), 0);
    chk("lit_lu_stall", int'(ifid_stall_o), 1);
    chk("lit_lu_idf", int'(idex_flush_o), 1);
    step(); clr_in(); #1;
    chk("lit_lu_cnt", int'(cnt_loaduse_o), 1);

    // load to x0: no hazard
    idex_memread_i = 1; idex_rd_i = 0; #1;
    chk("lit_x0_stall", int'(ifid_stall_o), 0);
    chk("lit_x0_pc", int'(pc_write_o), 1);
    step(); clr_in();

    // load-use beats branch, then branch alone
    idex_memread_i = 1; idex_rd_i = 7; ifid_rs1_i = 7; branch_taken_i = 1; #1;
    chk("lit_lubr_iff", int'(ifid_flush_o), 0);
    chk("lit_lubr_stall", int'(ifid_stall_o), 1);
    step(); clr_in(); branch_taken_i = 1; #1;
    chk("lit_br_iff", int'(ifid_flush_o), 1);
    chk("lit_br_pc", int'(pc_write_o), 1);
    step(); clr_in(); #1;
    chk("lit_br_cnt", int'(cnt_flush_o), 1);
    chk("lit_lu_cnt2", int'(cnt_loaduse_o), 2);

    // 10-cycle cache freeze with a taken branch pending
    dmem_stall_i = 1; branch_taken_i = 1; #1;
    chk("lit_ms_first", int'(mem_stall_o), 1);
    chk("lit_ms_state1", int'(state_o), 1);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("lit_ms_hold", int'(mem_stall_o), 1);
      chk("lit_ms_state2", int'(state_o), 2);
    end
    step(); dmem_stall_i = 0; #1;
    chk("lit_rel_iff", int'(ifid_flush_o), 1);
    chk("lit_rel_cnt_ms", int'(cnt_memstall_o), 10);
    chk("lit_rel_cnt_fl", int'(cnt_flush_o), 1);
    chk("lit_rel_err", int'(err_o), 1);
    step(); branch_taken_i = 0; #1;
    chk("lit_after_state", int'(state_o), 1);
    chk("lit_after_err", int'(err_o), 1);
    chk("lit_after_fl", int'(cnt_flush_o), 2);

    // reset in MEMWAIT clears everything
    dmem_stall_i = 1; step();
    rst_i = 1; step();
    rst_i = 0; dmem_stall_i = 0; #1;
    chk("lit_mrst_state", int'(state_o), 0);
    chk("lit_mrst_err", int'(err_o), 0);
    chk("lit_mrst_ms", int'(cnt_memstall_o), 0);

    // flush counter saturation
    start_i = 1; step(); start_i = 0; branch_taken_i = 1;
    repeat (20) step();
    branch_taken_i = 0; #1;
    chk("lit_sat_fl", int'(cnt_flush_o), CMAX);

    // randomized traffic, checked every cycle by the model
    run = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      rst_i          = ($urandom % 300) == 0;
      start_i        = ($urandom % 4) == 0;
      idex_memread_i = $urandom % 2;
      idex_rd_i      = 5'($urandom % 4);
      ifid_rs1_i     = 5'($urandom % 4);
      ifid_rs2_i     = 5'($urandom % 4);
      branch_taken_i = ($urandom % 4) == 0;
      if (run == 0 && ($urandom % 12) == 0) run = $urandom_range(1, 8);
      dmem_stall_i = (run > 0);
      if (run > 0) run--;
    end
    step(); clr_in(); rst_i = 0;
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
